// File: rtl/mc_control_unit.sv
// Multi-cycle control FSM for the 8-register core: sequences fetch/decode/execute/memory/writeback.
// Define MC_CTRL_LINK_EN to implement BL (op 101); otherwise op 101 decodes as undefined.
module mc_control_unit #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  instr_in,
  input  logic         mem_ready,
  input  logic [3:0]   flags,
  output logic         mem_req,
  output logic         mem_we,
  output logic         adr_sel,
  output logic         ir_write,
  output logic         write_enable,
  output logic [2:0]   adr_dst,
  output logic [2:0]   adr_src1,
  output logic [2:0]   adr_src2,
  output logic         alu_src_a,
  output logic [1:0]   alu_src_b,
  output logic [2:0]   alu_ctrl,
  output logic [1:0]   result_src,
  output logic         flags_write,
  output logic [W-1:0] imm_ext,
  output logic         illegal
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM_RD, S_MEM_WR, S_WB, S_BRANCH, S_LINK_PC
  } state_t;

  localparam logic [2:0] OP_ALU_R = 3'b000;
  localparam logic [2:0] OP_ALU_I = 3'b001;
  localparam logic [2:0] OP_LDR   = 3'b010;
  localparam logic [2:0] OP_STR   = 3'b011;
  localparam logic [2:0] OP_B     = 3'b100;
  localparam logic [2:0] OP_BL    = 3'b101;

  localparam logic [2:0] REG_PC = 3'd7;
  localparam logic [2:0] REG_LR = 3'd6;

  state_t      state;
  logic [15:0] ir;

  logic [2:0] op, rd, rn, rm;
  logic       is_undef, is_branch, cond_true;
  logic       flag_v_unused;

  assign op = ir[15:13];
  assign rd = ir[12:10];
  assign rn = ir[9:7];
  assign rm = ir[6:4];
  assign flag_v_unused = flags[0];

`ifdef MC_CTRL_LINK_EN
  assign is_undef  = (op[2:1] == 2'b11);
  assign is_branch = (op == OP_B) || (op == OP_BL);
`else
  assign is_undef  = (op[2:1] == 2'b11) || (op == OP_BL);
  assign is_branch = (op == OP_B);
`endif

  // flags = {N,Z,C,V}; cond shares the rd field of branch encodings
  always_comb begin
    case (ir[12:10])
      3'b000:  cond_true = 1'b1;
      3'b001:  cond_true = flags[2];
      3'b010:  cond_true = !flags[2];
      3'b011:  cond_true = flags[1];
      3'b100:  cond_true = !flags[1];
      3'b101:  cond_true = flags[3];
      3'b110:  cond_true = !flags[3];
      default: cond_true = 1'b0;
    endcase
  end

  // NOTE: state and IR use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      ir    <= '0;
    end else begin
      case (state)
        S_FETCH: if (mem_ready) begin
          ir    <= instr_in;
          state <= S_DECODE;
        end
        S_DECODE: begin
          if (is_undef)       state <= S_FETCH;
          else if (is_branch) state <= S_BRANCH;
          else                state <= S_EXEC;
        end
        S_EXEC: begin
          case (op)
            OP_LDR:  state <= S_MEM_RD;
            OP_STR:  state <= S_MEM_WR;
            default: state <= S_WB;
          endcase
        end
        S_MEM_RD: if (mem_ready) state <= S_WB;
        S_MEM_WR: if (mem_ready) state <= S_FETCH;
`ifdef MC_CTRL_LINK_EN
        S_BRANCH: state <= (op == OP_BL && cond_true) ? S_LINK_PC : S_FETCH;
`endif
        default: state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    imm_ext = '0;
    if (!reset) begin
      case (op)
        OP_ALU_I, OP_LDR, OP_STR: imm_ext = W'(ir[6:0]);
        OP_B, OP_BL:              imm_ext = W'($signed(ir[9:0]));
        default:                  imm_ext = '0;
      endcase
    end
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    adr_sel      = 1'b0;
    ir_write     = 1'b0;
    write_enable = 1'b0;
    adr_dst      = 3'd0;
    adr_src1     = 3'd0;
    adr_src2     = 3'd0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    alu_ctrl     = 3'b000;
    result_src   = 2'b00;
    flags_write  = 1'b0;
    illegal      = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          mem_req      = 1'b1;
          alu_src_a    = 1'b1;
          alu_src_b    = 2'b10;
          adr_dst      = REG_PC;
          ir_write     = mem_ready;
          write_enable = mem_ready;
        end
        S_DECODE: begin
          adr_src1 = rn;
          adr_src2 = (op == OP_STR) ? rd : rm;
          illegal  = is_undef;
        end
        S_EXEC: begin
          if (op == OP_ALU_R) begin
            alu_ctrl    = ir[2:0];
            flags_write = ir[3];
          end else begin
            alu_src_b = 2'b01;
          end
        end
        S_MEM_RD: begin
          mem_req = 1'b1;
          adr_sel = 1'b1;
        end
        S_MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          adr_sel = 1'b1;
        end
        S_WB: begin
          write_enable = 1'b1;
          adr_dst      = rd;
          result_src   = (op == OP_LDR) ? 2'b01 : 2'b00;
        end
        S_BRANCH: begin
          if (cond_true && op == OP_B) begin
            write_enable = 1'b1;
            adr_dst      = REG_PC;
            alu_src_a    = 1'b1;
            alu_src_b    = 2'b01;
          end
`ifdef MC_CTRL_LINK_EN
          if (cond_true && op == OP_BL) begin
            write_enable = 1'b1;
            adr_dst      = REG_LR;
            result_src   = 2'b10;
          end
`endif
        end
        S_LINK_PC: begin
          write_enable = 1'b1;
          adr_dst      = REG_PC;
          alu_src_a    = 1'b1;
          alu_src_b    = 2'b01;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: stimulus pushes per-cycle expected outputs, a monitor compares.
module tb_mc_control_unit;

  localparam int W = 8;

  typedef struct packed {
    logic         mem_req;
    logic         mem_we;
    logic         adr_sel;
    logic         ir_write;
    logic         write_enable;
    logic [2:0]   adr_dst;
    logic [2:0]   adr_src1;
    logic [2:0]   adr_src2;
    logic         alu_src_a;
    logic [1:0]   alu_src_b;
    logic [2:0]   alu_ctrl;
    logic [1:0]   result_src;
    logic         flags_write;
    logic [W-1:0] imm_ext;
    logic         illegal;
  } out_t;

  typedef struct {
    out_t  o;
    bit    chk_src;
    string name;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  instr_in;
  logic         mem_ready;
  logic [3:0]   flags;
  logic         mem_req, mem_we, adr_sel, ir_write, write_enable;
  logic [2:0]   adr_dst, adr_src1, adr_src2;
  logic         alu_src_a;
  logic [1:0]   alu_src_b;
  logic [2:0]   alu_ctrl;
  logic [1:0]   result_src;
  logic         flags_write;
  logic [W-1:0] imm_ext;
  logic         illegal;

  mc_control_unit #(.W(W)) dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .mem_ready(mem_ready), .flags(flags),
    .mem_req(mem_req), .mem_we(mem_we), .adr_sel(adr_sel), .ir_write(ir_write),
    .write_enable(write_enable), .adr_dst(adr_dst), .adr_src1(adr_src1), .adr_src2(adr_src2),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .result_src(result_src),
    .flags_write(flags_write), .imm_ext(imm_ext), .illegal(illegal)
  );

  always #5 clk = ~clk;

  exp_t         sb_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] ir_imm;

  out_t act;
  assign act = {mem_req, mem_we, adr_sel, ir_write, write_enable, adr_dst, adr_src1, adr_src2,
                alu_src_a, alu_src_b, alu_ctrl, result_src, flags_write, imm_ext, illegal};

  // Register addresses are only meaningful where they are driven with intent.
  exp_t e_cur;
  out_t a_m, e_m;
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      e_cur = sb_q.pop_front();
      a_m = act;
      e_m = e_cur.o;
      if (!e_m.write_enable) begin
        a_m.adr_dst = 3'd0;
        e_m.adr_dst = 3'd0;
      end
      if (!e_cur.chk_src) begin
        a_m.adr_src1 = 3'd0; a_m.adr_src2 = 3'd0;
        e_m.adr_src1 = 3'd0; e_m.adr_src2 = 3'd0;
      end
      checks++;
      if (a_m !== e_m) begin
        errors++;
        $display("FAIL %s: got %08h expected %08h (t=%0t)", e_cur.name, a_m, e_m, $time);
      end
    end
  end

  function automatic out_t o_zero();
    out_t o;
    o = '0;
    return o;
  endfunction

  function automatic out_t o_idle(input logic [W-1:0] imm);
    out_t o;
    o = '0;
    o.imm_ext = imm;
    return o;
  endfunction

  task automatic step(input logic rst, input logic rdy, input logic [15:0] ins,
                      input logic [3:0] flg, input out_t e, input bit cs, input string nm);
    exp_t x;
    reset = rst; mem_ready = rdy; instr_in = ins; flags = flg;
    x.o = e; x.chk_src = cs; x.name = nm;
    sb_q.push_back(x);
    @(posedge clk); #1;
  endtask

  task automatic fetch(input logic [15:0] ins, input logic [W-1:0] imm, input int waits);
    out_t o;
    o = o_idle(ir_imm);
    o.mem_req = 1'b1; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.adr_dst = 3'd7;
    for (int i = 0; i < waits; i++) step(1'b0, 1'b0, ins, 4'h0, o, 1'b0, "fetch_wait");
    o.write_enable = 1'b1; o.ir_write = 1'b1;
    step(1'b0, 1'b1, ins, 4'h0, o, 1'b0, "fetch");
    ir_imm = imm;
  endtask

  task automatic decode(input logic [2:0] rn, input logic [2:0] src2, input logic ill);
    out_t o;
    o = o_idle(ir_imm);
    o.adr_src1 = rn; o.adr_src2 = src2; o.illegal = ill;
    step(1'b0, 1'b1, 16'h0, 4'h0, o, 1'b1, "decode");
  endtask

  task automatic exec(input logic [1:0] srcb, input logic [2:0] ctrl, input logic fw);
    out_t o;
    o = o_idle(ir_imm);
    o.alu_src_b = srcb; o.alu_ctrl = ctrl; o.flags_write = fw;
    step(1'b0, 1'b1, 16'h0, 4'h0, o, 1'b0, "exec");
  endtask

  task automatic wb(input logic [2:0] rd, input logic [1:0] rs);
    out_t o;
    o = o_idle(ir_imm);
    o.write_enable = 1'b1; o.adr_dst = rd; o.result_src = rs;
    step(1'b0, 1'b1, 16'h0, 4'h0, o, 1'b0, "wb");
  endtask

  task automatic mem_access(input logic we, input logic rdy);
    out_t o;
    o = o_idle(ir_imm);
    o.mem_req = 1'b1; o.adr_sel = 1'b1; o.mem_we = we;
    step(1'b0, rdy, 16'h0, 4'h0, o, 1'b0, we ? "mem_wr" : "mem_rd");
  endtask

  task automatic pc_write(input logic [3:0] flg, input string nm);
    out_t o;
    o = o_idle(ir_imm);
    o.write_enable = 1'b1; o.adr_dst = 3'd7; o.alu_src_a = 1'b1; o.alu_src_b = 2'b01;
    step(1'b0, 1'b1, 16'h0, flg, o, 1'b0, nm);
  endtask

  initial begin
    ir_imm = '0;
    reset = 1'b1; mem_ready = 1'b1; instr_in = 16'h0; flags = 4'h0;
    @(posedge clk); #1;

    // Reset held three cycles, then the first FETCH
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 16'h0, 4'h0, o_zero(), 1'b1, "reset");
    fetch(16'h0000, 8'h00, 0);
    decode(3'd0, 3'd0, 1'b0); exec(2'b00, 3'b000, 1'b0); wb(3'd0, 2'b00);

    // ALU-R r1 = r1 op r1, funct 0100, one fetch wait
    fetch(16'h0494, 8'h00, 1);
    decode(3'd1, 3'd1, 1'b0); exec(2'b00, 3'b100, 1'b0); wb(3'd1, 2'b00);

    // ALU-R with flag update: rd=3, funct 1001
    fetch(16'h0C99, 8'h00, 0);
    decode(3'd1, 3'd1, 1'b0); exec(2'b00, 3'b001, 1'b1); wb(3'd3, 2'b00);

    // LDR r2 = mem[r1+3] with two memory wait cycles
    fetch(16'h4883, 8'h03, 0);
    decode(3'd1, 3'd0, 1'b0); exec(2'b01, 3'b000, 1'b0);
    mem_access(1'b0, 1'b0); mem_access(1'b0, 1'b0); mem_access(1'b0, 1'b1);
    wb(3'd2, 2'b01);

    // STR mem[r1+5] = r2, one wait; port 2 reads rd
    fetch(16'h6885, 8'h05, 0);
    decode(3'd1, 3'd2, 1'b0); exec(2'b01, 3'b000, 1'b0);
    mem_access(1'b1, 1'b0); mem_access(1'b1, 1'b1);

    // B EQ -2, Z=1 taken
    fetch(16'h87FE, 8'hFE, 0);
    decode(3'd7, 3'd7, 1'b0); pc_write(4'b0100, "beq_taken");

    // B EQ -2, Z=0 not taken
    fetch(16'h87FE, 8'hFE, 0);
    decode(3'd7, 3'd7, 1'b0);
    step(1'b0, 1'b1, 16'h0, 4'b1011, o_idle(8'hFE), 1'b0, "beq_not_taken");

    // B MI +5 with N=1 taken
    fetch(16'h9405, 8'h05, 0);
    decode(3'd0, 3'd0, 1'b0); pc_write(4'b1000, "bmi_taken");

    // B never, all flags set
    fetch(16'h9C00, 8'h00, 0);
    decode(3'd0, 3'd0, 1'b0);
    step(1'b0, 1'b1, 16'h0, 4'b1111, o_idle(8'h00), 1'b0, "bnv_not_taken");

    // BL always +5
    fetch(16'hA005, 8'h05, 0);
`ifdef MC_CTRL_LINK_EN
    decode(3'd0, 3'd0, 1'b0);
    begin
      out_t o;
      o = o_idle(8'h05);
      o.write_enable = 1'b1; o.adr_dst = 3'd6; o.result_src = 2'b10;
      step(1'b0, 1'b1, 16'h0, 4'h0, o, 1'b0, "bl_link");
    end
    pc_write(4'h0, "bl_pc");
`else
    decode(3'd0, 3'd0, 1'b1);
`endif

    // Undefined opcode: one illegal pulse, straight back to FETCH
    fetch(16'hE000, 8'h00, 0);
    decode(3'd0, 3'd0, 1'b1);

    // Reset during EXEC abandons the instruction
    fetch(16'h0494, 8'h00, 0);
    decode(3'd1, 3'd1, 1'b0);
    step(1'b1, 1'b1, 16'h0, 4'h0, o_zero(), 1'b1, "reset_mid");
    ir_imm = '0;
    fetch(16'h4883, 8'h03, 0);
    decode(3'd1, 3'd0, 1'b0);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
